// File: rtl/layer_controller.sv
// Sequencer for one neural-network layer: steps a shared multiply-accumulate
// datapath through every input of every neuron, then holds done until acknowledged.
module layer_controller #(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 8
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic                                       abort,
    input  logic                                       ack,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       mac_clear,
    output logic                                       mac_enable,
    output logic                                       act_enable,
    output logic                                       result_write,
    output logic [$clog2(NUM_INPUTS)-1:0]              input_index,
    output logic [$clog2(NUM_NEURONS)-1:0]             neuron_index,
    output logic [$clog2(NUM_INPUTS*NUM_NEURONS)-1:0]  weight_address
);

    localparam int IW = $clog2(NUM_INPUTS);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam int AW = $clog2(NUM_INPUTS*NUM_NEURONS);
    localparam logic [IW-1:0] LAST_INPUT  = IW'(NUM_INPUTS - 1);
    localparam logic [NW-1:0] LAST_NEURON = NW'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        ACCUM    = 3'd2,
        DRAIN    = 3'd3,
        ACTIVATE = 3'd4,
        WRITE    = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t          state;
    logic [IW-1:0]   in_cnt;
    logic [NW-1:0]   nr_cnt;

    // Abort only cancels an active pass; IDLE and DONE handle it in their own arms.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            in_cnt <= '0;
            nr_cnt <= '0;
        end else if (abort && state != IDLE && state != DONE) begin
            state  <= IDLE;
            in_cnt <= '0;
            nr_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_cnt <= '0;
                    nr_cnt <= '0;
                    if (start) state <= CLEAR;
                end
                CLEAR: state <= ACCUM;
                ACCUM: begin
                    if (in_cnt == LAST_INPUT) begin
                        in_cnt <= '0;
                        state  <= DRAIN;
                    end else begin
                        in_cnt <= in_cnt + 1'b1;
                    end
                end
                DRAIN:    state <= ACTIVATE;
                ACTIVATE: state <= WRITE;
                WRITE: begin
                    if (nr_cnt == LAST_NEURON) begin
                        state <= DONE;
                    end else begin
                        nr_cnt <= nr_cnt + 1'b1;
                        state  <= CLEAR;
                    end
                end
                DONE: begin
                    if (ack || abort) begin
                        state  <= IDLE;
                        in_cnt <= '0;
                        nr_cnt <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    in_cnt <= '0;
                    nr_cnt <= '0;
                end
            endcase
        end
    end

    // Strobes decode from distinct states, so they can never overlap.
    assign busy         = (state == CLEAR) || (state == ACCUM) || (state == DRAIN) ||
                          (state == ACTIVATE) || (state == WRITE);
    assign done         = (state == DONE);
    assign mac_clear    = (state == CLEAR);
    assign mac_enable   = (state == ACCUM);
    assign act_enable   = (state == ACTIVATE);
    assign result_write = (state == WRITE);

    assign input_index    = in_cnt;
    assign neuron_index   = nr_cnt;
    assign weight_address = AW'(nr_cnt) * AW'(NUM_INPUTS) + AW'(in_cnt);

endmodule

// File: tb/tb_layer_controller.sv
// Bench for layer_controller (4 inputs, 3 neurons): directed vector table,
// hand-written corner sequences and random traffic against a cycle-count model.
module tb_layer_controller;

    localparam int NI   = 4;
    localparam int NN   = 3;
    localparam int PER  = NI + 4;
    localparam int PASS = NN * PER;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ack   = 1'b0;
    logic       busy, done, mac_clear, mac_enable, act_enable, result_write;
    logic [1:0] input_index;
    logic [1:0] neuron_index;
    logic [3:0] weight_address;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    layer_controller #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .ack(ack),
        .busy(busy), .done(done), .mac_clear(mac_clear), .mac_enable(mac_enable),
        .act_enable(act_enable), .result_write(result_write),
        .input_index(input_index), .neuron_index(neuron_index),
        .weight_address(weight_address)
    );

    // Packed view: {busy, done, clear, enable, act, write, neuron, input, address}
    function automatic logic [13:0] pk(logic b, logic d, logic [3:0] s, int n, int i);
        logic [1:0] n2, i2;
        logic [3:0] wa;
        int         a;
        n2 = 2'(n);
        i2 = 2'(i);
        a  = n * NI + i;
        wa = 4'(a);
        return {b, d, s, n2, i2, wa};
    endfunction

    function automatic logic [13:0] outv();
        return {busy, done, mac_clear, mac_enable, act_enable, result_write,
                neuron_index, input_index, weight_address};
    endfunction

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a pass is just a cycle count 0..PASS-1; each neuron owns PER cycles
    // laid out as clear, NI accumulates, drain, activate, write.
    int m_mode = 0;   // 0 idle, 1 running, 2 done
    int m_cyc  = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode <= 0;
            m_cyc  <= 0;
        end else begin
            case (m_mode)
                0: if (start) begin m_mode <= 1; m_cyc <= 0; end
                1: begin
                    if (abort) begin m_mode <= 0; m_cyc <= 0; end
                    else if (m_cyc == PASS - 1) m_mode <= 2;
                    else m_cyc <= m_cyc + 1;
                end
                default: if (ack || abort) begin m_mode <= 0; m_cyc <= 0; end
            endcase
        end
    end

    function automatic logic [13:0] model_out();
        int n, p, i;
        logic [3:0] s;
        if (reset || m_mode == 0) return 14'd0;
        if (m_mode == 2) return pk(1'b0, 1'b1, 4'b0000, NN - 1, 0);
        n = m_cyc / PER;
        p = m_cyc % PER;
        i = (p >= 1 && p <= NI) ? p - 1 : 0;
        s = {p == 0, p >= 1 && p <= NI, p == NI + 2, p == NI + 3};
        return pk(1'b1, 1'b0, s, n, i);
    endfunction

    always @(negedge clock) check("cycle_model", int'(outv()), int'(model_out()));

    task automatic step(logic s, logic a, logic k);
        start = s;
        abort = a;
        ack   = k;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        s, a, k;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[15];
    int   cycles;
    int   wq[$];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, pk(0, 0, 4'b0000, 0, 0)};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, pk(1, 0, 4'b1000, 0, 0)};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, pk(1, 0, 4'b0100, 0, 0)};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, pk(1, 0, 4'b0100, 0, 1)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, pk(1, 0, 4'b0100, 0, 2)};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, pk(1, 0, 4'b0100, 0, 3)};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, pk(1, 0, 4'b0000, 0, 0)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, pk(1, 0, 4'b0010, 0, 0)};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, pk(1, 0, 4'b0001, 0, 0)};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, pk(1, 0, 4'b1000, 1, 0)};
        tbl[10] = '{1'b0, 1'b0, 1'b0, pk(1, 0, 4'b0100, 1, 0)};
        tbl[11] = '{1'b0, 1'b0, 1'b0, pk(1, 0, 4'b0100, 1, 1)};
        tbl[12] = '{1'b0, 1'b0, 1'b0, pk(1, 0, 4'b0100, 1, 2)};
        tbl[13] = '{1'b0, 1'b1, 1'b0, pk(0, 0, 4'b0000, 0, 0)};
        tbl[14] = '{1'b0, 1'b0, 1'b0, pk(0, 0, 4'b0000, 0, 0)};

        @(posedge clock);
        #1;
        check("reset_state", int'(outv()), 0);
        reset = 1'b0;
        step(0, 0, 0);

        for (int r = 0; r < 15; r++) begin
            step(tbl[r].s, tbl[r].a, tbl[r].k);
            check($sformatf("vec%0d", r), int'(outv()), int'(tbl[r].exp));
        end

        // Full pass with start held the whole way: no restart, done after PASS edges
        step(1, 0, 0);
        cycles = 0;
        while (!done && cycles < 40) begin
            if (result_write) wq.push_back(int'(neuron_index));
            step(1, 0, 0);
            cycles++;
        end
        check("pass_length", cycles, PASS);
        check("write_count", wq.size(), NN);
        for (int i = 0; i < wq.size(); i++) check("write_neuron", wq[i], i);

        for (int i = 0; i < 10; i++) begin
            step(logic'(i % 2), 0, 0);
            check("done_hold", int'(outv()), int'(pk(0, 1, 4'b0000, NN - 1, 0)));
        end
        step(0, 0, 1);
        check("ack_to_idle", int'(outv()), 0);

        step(1, 0, 0);
        repeat (PASS) step(0, 0, 0);
        check("done_again", int'(done), 1);
        step(0, 1, 1);
        check("abort_ack_done", int'(outv()), 0);

        step(1, 0, 0);
        repeat (2 * PER + 1) step(0, 0, 0);
        check("n2_accum", int'(outv()), int'(pk(1, 0, 4'b0100, 2, 0)));
        #3 reset = 1'b1;
        #1 check("async_reset", int'(outv()), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) step(0, 0, 0);
        check("idle_after_reset", int'(outv()), 0);

        for (int i = 0; i < 3000; i++)
            step(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 39) == 0),
                 logic'($urandom_range(0, 5) == 0));

        @(negedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
